// File: rtl/axis_mm_ws_acc_if.sv
// AXI-Stream style channel (data, valid, ready, last) shared by the matrix
// engine's input and result ports.
interface axis_mm_ws_acc_if #(
    parameter int W = 8
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_mm_ws_acc.sv
// Weight-stationary matrix multiply-accumulate: streams in W[K][Q] and A[P][K],
// accumulates C[P][Q] += A x W over P*K cycles, then streams C out saturated.
module axis_mm_ws_acc #(
    parameter int DW  = 8,
    parameter int OW  = 16,
    parameter int AW  = 32,
    parameter int P   = 8,
    parameter int K   = 8,
    parameter int Q   = 8,
    parameter int EPB = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cfg_load_w,
    input  logic              cfg_acc,
    input  logic              cfg_emit,
    axis_mm_ws_acc_if.slave   s_axis_i,
    axis_mm_ws_acc_if.master  m_axis_o,
    output logic              busy,
    output logic              done,
    output logic              err_tlast
);

    localparam int NW   = K * Q;
    localparam int NA   = P * K;
    localparam int NC   = P * Q;
    localparam int IW_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int IW_A = (NA > 1) ? $clog2(NA) : 1;
    localparam int IW_C = (NC > 1) ? $clog2(NC) : 1;
    localparam int IW_P = (P > 1) ? $clog2(P) : 1;
    localparam int IW_K = (K > 1) ? $clog2(K) : 1;
    localparam int LW   = $clog2(((NW > NA) ? NW : NA) + 1);
    localparam int PW   = 2 * DW;

    localparam logic signed [AW-1:0] OMAX = (AW'(1) <<< (OW - 1)) - AW'(1);
    localparam logic signed [AW-1:0] OMIN = -OMAX - AW'(1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_W  = 3'd1;
    localparam logic [2:0] S_LOAD_I  = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;

    logic [2:0]             state;
    logic                   cfg_acc_q;
    logic                   cfg_emit_q;
    logic [LW-1:0]          ld_cnt;
    logic [IW_P-1:0]        m_idx;
    logic [IW_K-1:0]        k_idx;
    logic [IW_C-1:0]        out_idx;
    logic signed [DW-1:0]   w_mem [NW];
    logic signed [DW-1:0]   a_mem [NA];
    logic signed [AW-1:0]   acc   [NC];

    logic beat;
    logic ld_last;
    logic c_last;
    logic o_fire;

    // Full-precision signed product, sign-extended to the accumulator width.
    function automatic logic signed [AW-1:0] mul_ext(input logic signed [DW-1:0] a,
                                                     input logic signed [DW-1:0] b);
        logic signed [PW-1:0] p;
        p = PW'(a) * PW'(b);
        return AW'(p);
    endfunction

    function automatic logic signed [OW-1:0] sat(input logic signed [AW-1:0] v);
        if (v > OMAX) return OW'(OMAX);
        if (v < OMIN) return OW'(OMIN);
        return OW'(v);
    endfunction

    assign beat    = s_axis_i.tvalid && s_axis_i.tready;
    assign ld_last = (int'(ld_cnt) + EPB) >= ((state == S_LOAD_W) ? NW : NA);
    assign c_last  = (m_idx == IW_P'(P - 1)) && (k_idx == IW_K'(K - 1));
    assign o_fire  = m_axis_o.tvalid && m_axis_o.tready;

    assign s_axis_i.tready = (state == S_LOAD_W) || (state == S_LOAD_I);
    assign busy            = (state != S_IDLE);
    assign m_axis_o.tvalid = (state == S_WRITE);
    assign m_axis_o.tlast  = (state == S_WRITE) && (out_idx == IW_C'(NC - 1));
    assign m_axis_o.tdata  = (state == S_WRITE) ? sat(acc[out_idx]) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cfg_acc_q  <= 1'b0;
            cfg_emit_q <= 1'b0;
            ld_cnt     <= '0;
            m_idx      <= '0;
            k_idx      <= '0;
            out_idx    <= '0;
            done       <= 1'b0;
            err_tlast  <= 1'b0;
            for (int i = 0; i < NW; i++) w_mem[i] <= '0;
            for (int i = 0; i < NA; i++) a_mem[i] <= '0;
            for (int i = 0; i < NC; i++) acc[i]   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cfg_acc_q  <= cfg_acc;
                        cfg_emit_q <= cfg_emit;
                        err_tlast  <= 1'b0;
                        ld_cnt     <= '0;
                        state      <= cfg_load_w ? S_LOAD_W : S_LOAD_I;
                    end
                end
                S_LOAD_W: begin
                    if (beat) begin
                        for (int e = 0; e < EPB; e++)
                            if (int'(ld_cnt) + e < NW)
                                w_mem[IW_W'(int'(ld_cnt) + e)] <= s_axis_i.tdata[e*DW +: DW];
                        // Either an early tlast or a missing final tlast closes the phase and flags framing.
                        if (ld_last || s_axis_i.tlast) begin
                            ld_cnt <= '0;
                            state  <= S_LOAD_I;
                            if (ld_last != s_axis_i.tlast) err_tlast <= 1'b1;
                        end else begin
                            ld_cnt <= ld_cnt + LW'(EPB);
                        end
                    end
                end
                S_LOAD_I: begin
                    if (beat) begin
                        for (int e = 0; e < EPB; e++)
                            if (int'(ld_cnt) + e < NA)
                                a_mem[IW_A'(int'(ld_cnt) + e)] <= s_axis_i.tdata[e*DW +: DW];
                        if (ld_last || s_axis_i.tlast) begin
                            ld_cnt <= '0;
                            m_idx  <= '0;
                            k_idx  <= '0;
                            state  <= S_COMPUTE;
                            if (ld_last != s_axis_i.tlast) err_tlast <= 1'b1;
                            if (!cfg_acc_q)
                                for (int i = 0; i < NC; i++) acc[i] <= '0;
                        end else begin
                            ld_cnt <= ld_cnt + LW'(EPB);
                        end
                    end
                end
                S_COMPUTE: begin
                    // One (m,k) pair per cycle, all Q columns of row m in parallel.
                    for (int q = 0; q < Q; q++)
                        acc[IW_C'(int'(m_idx) * Q + q)] <= acc[IW_C'(int'(m_idx) * Q + q)]
                            + mul_ext(a_mem[IW_A'(int'(m_idx) * K + int'(k_idx))],
                                      w_mem[IW_W'(int'(k_idx) * Q + q)]);
                    if (c_last) begin
                        m_idx   <= '0;
                        k_idx   <= '0;
                        out_idx <= '0;
                        if (cfg_emit_q) begin
                            state <= S_WRITE;
                        end else begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end else if (k_idx == IW_K'(K - 1)) begin
                        k_idx <= '0;
                        m_idx <= m_idx + IW_P'(1);
                    end else begin
                        k_idx <= k_idx + IW_K'(1);
                    end
                end
                S_WRITE: begin
                    if (o_fire) begin
                        if (out_idx == IW_C'(NC - 1)) begin
                            out_idx <= '0;
                            state   <= S_IDLE;
                            done    <= 1'b1;
                        end else begin
                            out_idx <= out_idx + IW_C'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_mm_ws_acc.sv
// Directed bench for the 2x2x2 matrix engine: expected results go into a
// scoreboard queue at job start and a separate monitor checks each output beat.
module tb_axis_mm_ws_acc;

    localparam int DW = 8, OW = 16, AW = 32, P = 2, K = 2, Q = 2, EPB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, cfg_load_w = 1'b0, cfg_acc = 1'b0, cfg_emit = 1'b0;
    logic busy, done, err_tlast;

    axis_mm_ws_acc_if #(.W(DW*EPB)) s_if ();
    axis_mm_ws_acc_if #(.W(OW))     m_if ();

    axis_mm_ws_acc #(.DW(DW), .OW(OW), .AW(AW), .P(P), .K(K), .Q(Q), .EPB(EPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_load_w (cfg_load_w),
        .cfg_acc    (cfg_acc),
        .cfg_emit   (cfg_emit),
        .s_axis_i   (s_if),
        .m_axis_o   (m_if),
        .busy       (busy),
        .done       (done),
        .err_tlast  (err_tlast)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int out_beats = 0;
    int bp_left = 0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [15:0] pk(input int e0, input int e1);
        logic [7:0] b0, b1;
        b0 = 8'(e0);
        b1 = 8'(e1);
        return {b1, b0};
    endfunction

    task automatic push4(input int c0, input int c1, input int c2, input int c3);
        exp_q.push_back('{data: c0, last: 1'b0});
        exp_q.push_back('{data: c1, last: 1'b0});
        exp_q.push_back('{data: c2, last: 1'b0});
        exp_q.push_back('{data: c3, last: 1'b1});
    endtask

    task automatic do_start(input bit lw, input bit ac, input bit em);
        @(negedge clk);
        start = 1'b1; cfg_load_w = lw; cfg_acc = ac; cfg_emit = em;
        @(posedge clk);
        #1;
        start = 1'b0; cfg_load_w = 1'b0; cfg_acc = 1'b0; cfg_emit = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] d, input bit last);
        int t;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = last;
        t = 0;
        @(negedge clk);
        while (!s_if.tready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!s_if.tready) begin
            check("beat_accept", 0, 1);
        end else begin
            @(posedge clk);
            #1;
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", int'(seen), 1);
        if (seen) begin
            check("busy_at_done", int'(busy), 0);
            @(negedge clk);
            check("done_one_cycle", int'(done), 0);
        end
    endtask

    // Output sink: ready is normally high; a requested stall holds it low while beat 1 is presented.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (bp_left > 0 && out_beats == 1) begin
                m_if.tready = 1'b0;
                bp_left--;
            end else begin
                m_if.tready = 1'b1;
            end
        end
    end

    // Monitor: pops on every transfer, checks hold-stable while stalled.
    always @(negedge clk) begin
        if (rst_n && m_if.tvalid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got %0d, expected no beat", $signed(m_if.tdata));
            end else if (m_if.tready) begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", int'($signed(m_if.tdata)), e.data);
                check("out_last", int'(m_if.tlast), int'(e.last));
                out_beats++;
            end else begin
                check("stall_data", int'($signed(m_if.tdata)), exp_q[0].data);
                check("stall_last", int'(m_if.tlast), int'(exp_q[0].last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   int'(busy), 0);
        check("rst_done",   int'(done), 0);
        check("rst_err",    int'(err_tlast), 0);
        check("rst_iready", int'(s_if.tready), 0);
        check("rst_ovalid", int'(m_if.tvalid), 0);
        check("rst_olast",  int'(m_if.tlast), 0);
        check("rst_odata",  int'(m_if.tdata), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic job with a 3-cycle output stall at beat 1
        bp_left = 3;
        push4(23, 34, 31, 46);
        do_start(1'b1, 1'b0, 1'b1);
        check("busy_after_start", int'(busy), 1);
        send_beat(pk(1, 2), 1'b0);
        send_beat(pk(3, 4), 1'b1);
        send_beat(pk(5, 6), 1'b0);
        send_beat(pk(7, 8), 1'b1);
        wait_done();
        check("err_clean_job", int'(err_tlast), 0);

        // Reuse stored W, accumulate onto previous C
        push4(46, 68, 62, 92);
        do_start(1'b0, 1'b1, 1'b1);
        send_beat(pk(5, 6), 1'b0);
        send_beat(pk(7, 8), 1'b1);
        wait_done();

        // Positive saturation
        push4(32767, 32767, 32767, 32767);
        do_start(1'b1, 1'b0, 1'b1);
        send_beat(pk(-128, -128), 1'b0);
        send_beat(pk(-128, -128), 1'b1);
        send_beat(pk(-128, -128), 1'b0);
        send_beat(pk(-128, -128), 1'b1);
        wait_done();

        // In-range negative result
        push4(-32512, -32512, -32512, -32512);
        do_start(1'b1, 1'b0, 1'b1);
        send_beat(pk(127, 127), 1'b0);
        send_beat(pk(127, 127), 1'b1);
        send_beat(pk(-128, -128), 1'b0);
        send_beat(pk(-128, -128), 1'b1);
        wait_done();

        // Early tlast on first W beat: W row 1 keeps 127s from the previous job
        push4(767, 772, 1023, 1030);
        do_start(1'b1, 1'b0, 1'b1);
        send_beat(pk(1, 2), 1'b1);
        check("err_early_tlast", int'(err_tlast), 1);
        check("iready_in_load_i", int'(s_if.tready), 1);
        send_beat(pk(5, 6), 1'b0);
        send_beat(pk(7, 8), 1'b1);
        wait_done();
        check("err_sticky", int'(err_tlast), 1);

        // Reset during WRITE after two beats have transferred
        push4(23, 34, 31, 46);
        do_start(1'b1, 1'b0, 1'b1);
        check("err_cleared_on_start", int'(err_tlast), 0);
        send_beat(pk(1, 2), 1'b0);
        send_beat(pk(3, 4), 1'b1);
        send_beat(pk(5, 6), 1'b0);
        send_beat(pk(7, 8), 1'b1);
        base = out_beats - 0;
        base = out_beats;
        for (int t = 0; t < 100 && out_beats < base + 2; t++) begin
            @(negedge clk);
            #1;
        end
        check("two_beats_before_reset", out_beats - base, 2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ovalid", int'(m_if.tvalid), 0);
        check("midrst_odata",  int'(m_if.tdata), 0);
        check("midrst_olast",  int'(m_if.tlast), 0);
        check("midrst_busy",   int'(busy), 0);
        check("midrst_iready", int'(s_if.tready), 0);
        check("midrst_done",   int'(done), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_done_after_abort", int'(done), 0);
        end

        // Rerun of the basic job from clean state
        push4(23, 34, 31, 46);
        do_start(1'b1, 1'b0, 1'b1);
        send_beat(pk(1, 2), 1'b0);
        send_beat(pk(3, 4), 1'b1);
        send_beat(pk(5, 6), 1'b0);
        send_beat(pk(7, 8), 1'b1);
        wait_done();

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_mm_ws_acc.md
AXIS_MM_WS_ACC -- requirements
Module: axis_mm_ws_acc

Interface
REQ-001 SHALL have parameter DW, default 8: signed input element width.
REQ-002 SHALL have parameter OW, default 16: signed output element width.
REQ-003 SHALL have parameter AW, default 32: signed internal accumulator width.
REQ-004 SHALL have parameters P, K, Q, defaults 8, 8, 8: rows of A, inner dimension, and columns of W; it computes C[P][Q] = A[P][K] x W[K][Q].
REQ-005 SHALL have parameter EPB, default 1: elements per input beat; both K*Q and P*K are multiples of EPB.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  job start pulse, sampled only in IDLE.
REQ-009 cfg_load_w  in  1  job loads a new W; 0 reuses the stored W.
REQ-010 cfg_acc  in  1  accumulate onto the existing accumulators; 0 clears them first.
REQ-011 cfg_emit  in  1  stream C out after compute; 0 skips the output phase.
REQ-012 s_axis_i_tdata/tvalid/tready/tlast  in/in/out/in  DW*EPB/1/1/1  input stream; element e is in bits [(e+1)*DW-1 : e*DW], lowest lane first.
REQ-013 m_axis_o_tdata/tvalid/tready/tlast  out/out/in/out  OW/1/1/1  result stream, one element per beat.
REQ-014 busy  out  1  high whenever the state is not IDLE.
REQ-015 done  out  1  one-cycle pulse on return to IDLE.
REQ-016 err_tlast  out  1  sticky tlast-framing error, cleared on an accepted start.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD_W, LOAD_I, COMPUTE and WRITE.
REQ-018 In IDLE, start=1 SHALL latch the cfg_* inputs, clear err_tlast, and go to LOAD_W if cfg_load_w=1, else to LOAD_I; start outside IDLE SHALL be ignored.
REQ-019 s_axis_i_tready SHALL be 1 exactly in LOAD_W and LOAD_I; a beat transfers when tvalid and tready are both 1.
REQ-020 LOAD_W SHALL store K*Q elements row-major as W[k][q], then go to LOAD_I.
REQ-021 LOAD_I SHALL store P*K elements row-major as A[m][k], then go to COMPUTE.
REQ-022 The state change SHALL occur on the clock edge that transfers the final beat.
REQ-023 A beat with tlast=1 before the final beat SHALL end the phase early, leave unwritten elements at their prior values, and set err_tlast.
REQ-024 A final beat without tlast SHALL still end the phase and SHALL set err_tlast.
REQ-025 On COMPUTE entry, the P x Q AW-bit accumulators SHALL be zeroed if the latched cfg_acc=0, and kept otherwise.
REQ-026 COMPUTE SHALL last exactly P*K cycles.
REQ-027 Each COMPUTE cycle SHALL handle one (m,k) pair, m outer and k inner, in Q parallel lanes: acc[m][q] += A[m][k]*W[k][q].
REQ-028 Products SHALL be full-precision signed and sign-extended to AW; accumulation SHALL wrap modulo 2^AW.
REQ-029 After COMPUTE, the FSM SHALL go to WRITE if the latched cfg_emit=1, else to IDLE.
REQ-030 WRITE SHALL emit C in row-major order, P*Q beats, each saturated from AW to signed OW range [-2^(OW-1), 2^(OW-1)-1].
REQ-031 m_axis_o_tlast SHALL be 1 only on beat P*Q-1.
REQ-032 The first m_axis_o_tvalid SHALL occur in the cycle after COMPUTE ends.
REQ-033 While tvalid=1 and tready=0, tdata and tlast SHALL hold stable.
REQ-034 After the tlast beat transfers, the FSM SHALL go to IDLE and tvalid SHALL drop in the same edge.
REQ-035 done SHALL pulse for one cycle on every transition into IDLE from COMPUTE or WRITE.
REQ-036 The W buffer SHALL persist across jobs until overwritten by a load or reset; accumulators SHALL persist until cleared or reset.

Reset
REQ-037 rst_n=0 SHALL immediately force state IDLE and drive s_axis_i_tready, m_axis_o_tvalid, m_axis_o_tlast, busy, done and err_tlast to 0, with m_axis_o_tdata=0.
REQ-038 rst_n=0 SHALL zero all W, A and accumulator storage and all counters.
REQ-039 Reset asserted mid-job (any state) SHALL abort the job with no done pulse; the next job starts from clean state.

Verification (P=K=Q=2, EPB=2, DW=8, OW=16, AW=32)
REQ-040 Basic: start with load_w=1, acc=0, emit=1; W beats {1,2},{3,4}; A beats {5,6},{7,8} -> out 23, 34, 31, 46, tlast on 46, done pulse, busy falls.
REQ-041 Reuse+accumulate: same A, load_w=0, acc=1 -> no LOAD_W beats accepted; out 46, 68, 62, 92.
REQ-042 Saturation: A all -128, W all -128, acc=0 -> every output 32767; all -128 A with all 127 W -> every output -32512.
REQ-043 Backpressure: during REQ-040, hold m_axis_o_tready=0 for 3 cycles at beat 1 -> tdata stays 34 with tvalid=1; the sequence and count are unchanged.
REQ-044 Framing: tlast on the first W beat -> err_tlast=1 and the FSM proceeds to LOAD_I; the next start clears err_tlast.
REQ-045 Reset mid-WRITE after 2 beats -> outputs 0 immediately; a rerun of REQ-040 with load_w=1 yields 23, 34, 31, 46.
